// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT streaming frontend.
package ntt_pkg;

  localparam int NTT_N           = 256;
  localparam int NTT_ADDR_WIDTH  = 8;
  localparam int NTT_COEFF_WIDTH = 12;
  localparam int BITREV_MAX_W    = 16;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_UNLOAD
  } fe_state_t;

  // Reverses the low w bits of v; callers pass v zero-extended from w bits.
  function automatic logic [BITREV_MAX_W-1:0] bit_reverse(input logic [BITREV_MAX_W-1:0] v,
                                                           input int w);
    logic [BITREV_MAX_W-1:0] r;
    r = {<<{v}};
    return r >> (BITREV_MAX_W - w);
  endfunction

endpackage

// File: rtl/ntt_skid_fifo.sv
// Two-entry FIFO buffering RAM read data ahead of the output stream.
// Head is visible combinationally; a push into a full FIFO is dropped unless a pop frees a slot.
module ntt_skid_fifo #(
  parameter int WIDTH = 13
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_count = r_count;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ntt_stream_frontend.sv
// Loads N coefficients into the NTT RAM, runs ntt_control, streams results out.
// Input beat written same cycle; first output 2 cycles into UNLOAD, 1 beat/cycle; out stalls hold data.
module ntt_stream_frontend
  import ntt_pkg::*;
#(
  parameter int   N           = NTT_N,
  parameter int   ADDR_WIDTH  = NTT_ADDR_WIDTH,
  parameter int   COEFF_WIDTH = NTT_COEFF_WIDTH,
  parameter logic BITREV_IN   = 1'b0,
  parameter logic BITREV_OUT  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COEFF_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COEFF_WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   ntt_start,
  input  logic                   ntt_done,
  output logic                   mem_owner,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [COEFF_WIDTH-1:0] mem_wdata,
  output logic                   mem_we,
  output logic                   mem_re,
  input  logic [COEFF_WIDTH-1:0] mem_rdata,
  output logic                   frame_err
);

  localparam int              CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] NUM_BEATS = CNT_W'(N);

  fe_state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, r_rcnt;
  logic                   r_in_rdy, r_rd_pend, r_pend_last, r_frame_err;
  logic                   w_in_hs, w_cnt_last, w_issue, w_out_hs, w_head_last;
  logic [1:0]             w_fifo_cnt, w_credit_used;
  logic                   w_full, w_empty;
  logic [COEFF_WIDTH:0]   w_head;
  logic [ADDR_WIDTH-1:0]  w_wr_addr, w_rd_addr;

  assign w_in_hs     = (r_state == ST_LOAD) && in_valid && r_in_rdy;
  assign w_cnt_last  = (r_cnt == LAST_IDX);
  assign w_head_last = w_head[COEFF_WIDTH];
  assign w_out_hs    = !w_empty && out_ready;

  assign w_wr_addr = BITREV_IN ?
      ADDR_WIDTH'(bit_reverse(BITREV_MAX_W'(r_cnt[ADDR_WIDTH-1:0]), ADDR_WIDTH)) :
      r_cnt[ADDR_WIDTH-1:0];
  assign w_rd_addr = BITREV_OUT ?
      ADDR_WIDTH'(bit_reverse(BITREV_MAX_W'(r_rcnt[ADDR_WIDTH-1:0]), ADDR_WIDTH)) :
      r_rcnt[ADDR_WIDTH-1:0];

  // Credits count the slot freed by this cycle's pop so a held-ready sink sees 1 beat/cycle.
  assign w_credit_used = w_fifo_cnt - {1'b0, w_out_hs} + {1'b0, r_rd_pend};
  assign w_issue = (r_state == ST_UNLOAD) && (r_rcnt < NUM_BEATS) &&
                   (w_credit_used < 2'd2) && !(w_full && !w_out_hs);

  assign in_ready  = r_in_rdy;
  assign frame_err = r_frame_err;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_head[COEFF_WIDTH-1:0];
  assign out_last  = !w_empty && w_head_last;

  ntt_skid_fifo #(.WIDTH(COEFF_WIDTH + 1)) u_fifo (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_push     (r_rd_pend),
    .i_push_dat ({r_pend_last, mem_rdata}),
    .i_pop      (w_out_hs),
    .o_head     (w_head),
    .o_count    (w_fifo_cnt),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    ntt_start   = 1'b0;
    mem_owner   = 1'b1;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (r_state)
      ST_LOAD: begin
        if (w_in_hs) begin
          mem_we    = 1'b1;
          mem_wdata = in_data;
          mem_addr  = w_wr_addr;
          if (w_cnt_last) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_owner = 1'b0;
        ntt_start = 1'b1;
        if (ntt_done) w_state_nxt = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (w_issue) begin
          mem_re   = 1'b1;
          mem_addr = w_rd_addr;
        end
        if (w_out_hs && w_head_last) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_cnt       <= '0;
      r_rcnt      <= '0;
      r_in_rdy    <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_pend_last <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_rdy    <= (w_state_nxt == ST_LOAD);
      r_rd_pend   <= w_issue;
      r_pend_last <= w_issue && (r_rcnt == LAST_IDX);
      if (w_in_hs) begin
        r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        if (in_last != w_cnt_last) r_frame_err <= 1'b1;
      end
      if (w_out_hs && w_head_last) r_rcnt <= '0;
      else if (w_issue)            r_rcnt <= r_rcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ntt_stream_frontend.sv
// Directed bench: stub RAM plus a done-after-10-cycles control stub around two frontends.
module tb_ntt_stream_frontend;

  localparam int N  = 256;
  localparam int AW = 8;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_data = '0;
  logic          ntt_done;

  logic          in_ready, out_valid, out_last, ntt_start, mem_owner, mem_we, mem_re, frame_err;
  logic [CW-1:0] out_data, mem_wdata, rdata;
  logic [AW-1:0] mem_addr;

  logic          b_in_ready, b_out_valid, b_out_last, b_ntt_start, b_mem_owner, b_mem_we, b_mem_re, b_frame_err;
  logic [CW-1:0] b_out_data, b_mem_wdata, b_rdata;
  logic [AW-1:0] b_mem_addr;

  logic [CW-1:0] ram [N];
  logic [CW-1:0] ram_br [N];
  int            done_cnt = 0;
  int            issued = 0;

  ntt_stream_frontend dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .ntt_start(ntt_start), .ntt_done(ntt_done), .mem_owner(mem_owner),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(rdata), .frame_err(frame_err)
  );

  ntt_stream_frontend #(.BITREV_IN(1'b1), .BITREV_OUT(1'b0)) dut_br (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .ntt_start(b_ntt_start), .ntt_done(ntt_done), .mem_owner(b_mem_owner),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
    .mem_rdata(b_rdata), .frame_err(b_frame_err)
  );

  assign ntt_done = ntt_start && (done_cnt == 10);

  always @(posedge clk) begin
    done_cnt <= ntt_start ? done_cnt + 1 : 0;
    if (mem_re) issued <= issued + 1;
    if (mem_owner && mem_we)     ram[mem_addr]      <= mem_wdata;
    if (mem_owner && mem_re)     rdata              <= ram[mem_addr];
    if (b_mem_owner && b_mem_we) ram_br[b_mem_addr] <= b_mem_wdata;
    if (b_mem_owner && b_mem_re) b_rdata            <= ram_br[b_mem_addr];
  end

  int n_chk = 0, n_pass = 0;
  int exp_d [N];
  int s_to_err;
  int r_beats, r_data_err, r_last_err, r_hold_err, r_outst_err, r_br_err;
  int r_start_cyc, r_lat, r_span, r_timeout;

  function automatic int br8(input int v);
    int r = 0;
    for (int i = 0; i < AW; i++) if (v[i]) r |= 1 << (AW - 1 - i);
    return r;
  endfunction

  task automatic send_frame(input int kind, input int last_at);
    s_to_err = 0;
    for (int k = 0; k < N; k++) begin
      int w;
      exp_d[k] = (kind == 0) ? k : ((k * 37 + 5) % 4096);
      in_valid = 1'b1;
      in_data  = CW'(exp_d[k]);
      in_last  = (k == last_at);
      w = 0;
      while (!in_ready && w < 100) begin @(negedge clk); w++; end
      if (!in_ready) s_to_err++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Runs at negedges from the first RUN cycle until out_last is taken or abort_at beats are seen.
  task automatic recv_frame(input int bp, input int abort_at);
    int fall, first, lastc, issued0;
    logic held, hl, done;
    logic [CW-1:0] hd;
    r_beats = 0; r_data_err = 0; r_last_err = 0; r_hold_err = 0; r_outst_err = 0;
    r_br_err = 0; r_start_cyc = 0; r_timeout = 0;
    fall = -1; first = -1; lastc = 0; issued0 = issued;
    held = 1'b0; hl = 1'b0; hd = '0; done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (abort_at >= 0 && r_beats == abort_at) begin
        rst = 1'b1;
        out_ready = 1'b0;
        return;
      end
      if (ntt_start) r_start_cyc++;
      else if (r_start_cyc > 0 && fall < 0) fall = cyc;
      if ((issued - issued0) - r_beats > 2) r_outst_err++;
      if ({in_ready, out_valid, out_last, ntt_start, mem_owner, frame_err} !==
          {b_in_ready, b_out_valid, b_out_last, b_ntt_start, b_mem_owner, b_frame_err}) r_br_err++;
      if (held && (!out_valid || out_data !== hd || out_last !== hl)) r_hold_err++;
      out_ready = (bp == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        if (out_data !== CW'(exp_d[r_beats])) r_data_err++;
        if (b_out_data !== CW'(exp_d[br8(r_beats)])) r_data_err++;
        if (out_last !== (r_beats == N - 1)) r_last_err++;
        if (out_last) begin done = 1'b1; lastc = cyc; end
        r_beats++;
      end
      held = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
      @(negedge clk);
    end
    if (!done) r_timeout = 1;
    r_lat  = first - fall;
    r_span = lastc - first + 1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    in_valid = 1'b1;
    #12;
    n_chk++;
    if ({in_ready, out_valid, out_last, ntt_start, mem_we, mem_re, frame_err, mem_owner} !== 8'b0000_0001 ||
        out_data !== '0 || mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL reset_outputs flags=%b data=%h addr=%h wdata=%h required flags=00000001 zeros",
               {in_ready, out_valid, out_last, ntt_start, mem_we, mem_re, frame_err, mem_owner},
               out_data, mem_addr, mem_wdata);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    n_chk++;
    if (in_ready !== 1'b0) $display("FAIL reset_release_rdy got %b required 0", in_ready); else n_pass++;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL first_clk_rdy got %b required 1", in_ready); else n_pass++;
  endtask

  task automatic test_ramp;
    int bad;
    send_frame(0, 255);
    n_chk++;
    if (s_to_err != 0) $display("FAIL ramp_load_timeout got %0d required 0", s_to_err); else n_pass++;
    n_chk++;
    if (ntt_start !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL ramp_enter_run start=%b rdy=%b required 1 0", ntt_start, in_ready);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < N; k++) if (ram[k] !== CW'(k) || ram_br[br8(k)] !== CW'(k)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL ramp_ram_contents bad=%0d required 0", bad); else n_pass++;
    n_chk++;
    if (ram_br[128] !== 12'd1 || ram_br[192] !== 12'd3)
      $display("FAIL bitrev_addr got %0d %0d required 1 3", ram_br[128], ram_br[192]);
    else n_pass++;
    recv_frame(0, -1);
    n_chk++;
    if (r_timeout != 0 || r_beats != N) $display("FAIL ramp_beats got %0d to=%0d required 256", r_beats, r_timeout); else n_pass++;
    n_chk++;
    if (r_data_err != 0) $display("FAIL ramp_data errors=%0d required 0", r_data_err); else n_pass++;
    n_chk++;
    if (r_last_err != 0) $display("FAIL ramp_last errors=%0d required 0", r_last_err); else n_pass++;
    n_chk++;
    if (r_start_cyc != 11) $display("FAIL start_cycles got %0d required 11", r_start_cyc); else n_pass++;
    n_chk++;
    if (r_lat != 2) $display("FAIL first_valid_latency got %0d required 2", r_lat); else n_pass++;
    n_chk++;
    if (r_span != N) $display("FAIL throughput_span got %0d required 256", r_span); else n_pass++;
    n_chk++;
    if (r_br_err != 0 || r_outst_err != 0) $display("FAIL ramp_ctrl br=%0d outst=%0d required 0 0", r_br_err, r_outst_err); else n_pass++;
    n_chk++;
    if (frame_err !== 1'b0) $display("FAIL ramp_frame_err got %b required 0", frame_err); else n_pass++;
  endtask

  task automatic test_backpressure;
    send_frame(1, 255);
    recv_frame(1, -1);
    n_chk++;
    if (r_timeout != 0 || r_beats != N) $display("FAIL bp_beats got %0d to=%0d required 256", r_beats, r_timeout); else n_pass++;
    n_chk++;
    if (r_data_err != 0 || r_last_err != 0) $display("FAIL bp_data data=%0d last=%0d required 0 0", r_data_err, r_last_err); else n_pass++;
    n_chk++;
    if (r_hold_err != 0) $display("FAIL bp_hold errors=%0d required 0", r_hold_err); else n_pass++;
    n_chk++;
    if (r_outst_err != 0) $display("FAIL bp_outstanding errors=%0d required 0", r_outst_err); else n_pass++;
  endtask

  task automatic test_frame_err;
    send_frame(0, 100);
    n_chk++;
    if (frame_err !== 1'b1) $display("FAIL frame_err_set got %b required 1", frame_err); else n_pass++;
    n_chk++;
    if (s_to_err != 0 || ntt_start !== 1'b1) $display("FAIL err_frame_256 to=%0d start=%b required 0 1", s_to_err, ntt_start); else n_pass++;
    recv_frame(0, -1);
    n_chk++;
    if (r_beats != N || r_data_err != 0) $display("FAIL err_frame_out beats=%0d data=%0d required 256 0", r_beats, r_data_err); else n_pass++;
    send_frame(1, 255);
    recv_frame(0, -1);
    n_chk++;
    if (frame_err !== 1'b1) $display("FAIL frame_err_sticky got %b required 1", frame_err); else n_pass++;
  endtask

  task automatic test_reset_mid;
    send_frame(0, 255);
    recv_frame(0, 50);
    #1;
    n_chk++;
    if (r_beats != 50) $display("FAIL abort_point got %0d required 50", r_beats); else n_pass++;
    n_chk++;
    if ({in_ready, out_valid, out_last, ntt_start, mem_we, mem_re, frame_err, mem_owner} !== 8'b0000_0001 ||
        out_data !== '0 || mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL midreset_outputs flags=%b data=%h addr=%h required flags=00000001 zeros",
               {in_ready, out_valid, out_last, ntt_start, mem_we, mem_re, frame_err, mem_owner}, out_data, mem_addr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL midreset_rdy got %b required 1", in_ready); else n_pass++;
    send_frame(1, 255);
    recv_frame(0, -1);
    n_chk++;
    if (r_timeout != 0 || r_beats != N || r_data_err != 0 || r_last_err != 0)
      $display("FAIL fresh_frame beats=%0d data=%0d last=%0d required 256 0 0", r_beats, r_data_err, r_last_err);
    else n_pass++;
    n_chk++;
    if (frame_err !== 1'b0) $display("FAIL fresh_frame_err got %b required 0", frame_err); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_backpressure;
    test_frame_err;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
